// File: rtl/hazard_if.sv
// Bundle between the pipeline datapath and the hazard controller: ID/EX
// hazard sources in, pipeline-register enables and event counters out.
interface hazard_if;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        ex_mem_read;
    logic [4:0]  ex_rt;
    logic        ex_branch_taken;
    logic        resume;
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        id_nop;
    logic        halted;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    modport master (
        output id_opcode, id_rs, id_rt, ex_mem_read, ex_rt, ex_branch_taken, resume,
        input  pc_write, ifid_write, ifid_flush, id_nop, halted, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_opcode, id_rs, id_rt, ex_mem_read, ex_rt, ex_branch_taken, resume,
        output pc_write, ifid_write, ifid_flush, id_nop, halted, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: boot bubbles, load-use stall, taken-branch flush,
// halt drain/resume, plus saturating stall and flush event counters.
module hazard_ctrl (
    input  logic     clk,
    input  logic     rst_n,
    hazard_if.slave  hz
);
    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    localparam logic [5:0] OP_HALT = 6'b111111;

    state_t      state_r, state_s;
    logic [1:0]  boot_cnt_r, boot_cnt_s;
    logic [1:0]  drain_cnt_r, drain_cnt_s;
    logic [15:0] stall_cnt_r, flush_cnt_r;
    logic        uses_rs_s, uses_rt_s, load_use_s;
    logic        stall_inc_s, flush_inc_s;
    logic        pc_write_s, ifid_write_s, ifid_flush_s, id_nop_s, halted_s;

    function automatic logic op_uses_rs(input logic [5:0] op);
        case (op)
            6'b000000, 6'b001000, 6'b001001, 6'b000100,
            6'b000101, 6'b100011, 6'b101011: op_uses_rs = 1'b1;
            default:                         op_uses_rs = 1'b0;
        endcase
    endfunction

    function automatic logic op_uses_rt(input logic [5:0] op);
        case (op)
            6'b000000, 6'b000100, 6'b000101, 6'b101011: op_uses_rt = 1'b1;
            default:                                    op_uses_rt = 1'b0;
        endcase
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
        sat_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

    // Load-use detection against the lw currently in EX; r0 never creates a hazard
    always_comb begin
        uses_rs_s  = op_uses_rs(hz.id_opcode);
        uses_rt_s  = op_uses_rt(hz.id_opcode);
        load_use_s = hz.ex_mem_read && (hz.ex_rt != 5'd0) &&
                     ((uses_rs_s && (hz.ex_rt == hz.id_rs)) ||
                      (uses_rt_s && (hz.ex_rt == hz.id_rt)));
    end

    // Next-state and output decode; the freeze pattern is the default
    always_comb begin
        state_s      = state_r;
        boot_cnt_s   = boot_cnt_r;
        drain_cnt_s  = drain_cnt_r;
        pc_write_s   = 1'b0;
        ifid_write_s = 1'b0;
        ifid_flush_s = 1'b0;
        id_nop_s     = 1'b1;
        halted_s     = 1'b0;
        stall_inc_s  = 1'b0;
        flush_inc_s  = 1'b0;
        case (state_r)
            ST_BOOT: begin
                pc_write_s   = 1'b1;
                ifid_write_s = 1'b1;
                if (boot_cnt_r == 2'd1) begin
                    state_s    = ST_RUN;
                    boot_cnt_s = 2'd0;
                end else begin
                    boot_cnt_s = boot_cnt_r + 2'd1;
                end
            end
            ST_RUN: begin
                if (hz.ex_branch_taken) begin
                    // a wrong-path halt in ID is flushed here, so no drain starts
                    pc_write_s   = 1'b1;
                    ifid_write_s = 1'b1;
                    ifid_flush_s = 1'b1;
                    flush_inc_s  = 1'b1;
                end else if (load_use_s) begin
                    stall_inc_s = 1'b1;
                end else if (hz.id_opcode == OP_HALT) begin
                    state_s     = ST_DRAIN;
                    drain_cnt_s = 2'd0;
                end else begin
                    pc_write_s   = 1'b1;
                    ifid_write_s = 1'b1;
                    id_nop_s     = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_r == 2'd2) begin
                    state_s     = ST_HALTED;
                    drain_cnt_s = 2'd0;
                end else begin
                    drain_cnt_s = drain_cnt_r + 2'd1;
                end
            end
            ST_HALTED: begin
                halted_s = 1'b1;
                if (hz.resume) begin
                    // PC already points past the halt; only the halt in IF/ID is discarded
                    ifid_write_s = 1'b1;
                    ifid_flush_s = 1'b1;
                    state_s      = ST_RUN;
                end else begin
                    state_s = ST_HALTED;
                end
            end
            default: begin
                state_s     = ST_BOOT;
                boot_cnt_s  = 2'd0;
                drain_cnt_s = 2'd0;
            end
        endcase
    end

    // State and phase counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_BOOT;
            boot_cnt_r  <= 2'd0;
            drain_cnt_r <= 2'd0;
        end else begin
            state_r     <= state_s;
            boot_cnt_r  <= boot_cnt_s;
            drain_cnt_r <= drain_cnt_s;
        end
    end

    // Saturating event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= 16'd0;
            flush_cnt_r <= 16'd0;
        end else begin
            if (stall_inc_s) begin
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush_inc_s) begin
                flush_cnt_r <= sat_inc(flush_cnt_r);
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign hz.pc_write   = pc_write_s;
    assign hz.ifid_write = ifid_write_s;
    assign hz.ifid_flush = ifid_flush_s;
    assign hz.id_nop     = id_nop_s;
    assign hz.halted     = halted_s;
    assign hz.stall_cnt  = stall_cnt_r;
    assign hz.flush_cnt  = flush_cnt_r;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random traffic against a
// cycle-countdown reference model of the controller's behaviour.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    hazard_if bus();

    hazard_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: cycles of boot/drain still to go, halted flag, counters
    int          boot_left;
    int          drain_left;
    bit          halt_m;
    logic [15:0] stall_m;
    logic [15:0] flush_m;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        boot_left  = 2;
        drain_left = 0;
        halt_m     = 1'b0;
        stall_m    = 16'd0;
        flush_m    = 16'd0;
    endtask

    task automatic chk_boot_outputs(input string tag);
        chk({tag, ".pc_write"},   16'(bus.pc_write),   16'd1);
        chk({tag, ".ifid_write"}, 16'(bus.ifid_write), 16'd1);
        chk({tag, ".ifid_flush"}, 16'(bus.ifid_flush), 16'd0);
        chk({tag, ".id_nop"},     16'(bus.id_nop),     16'd1);
        chk({tag, ".halted"},     16'(bus.halted),     16'd0);
        chk({tag, ".stall_cnt"},  bus.stall_cnt,       16'd0);
        chk({tag, ".flush_cnt"},  bus.flush_cnt,       16'd0);
    endtask

    // One clock cycle: drive inputs (just after posedge), check at negedge, advance model at posedge
    task automatic step(input string tag, input logic [5:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic mr, input logic [4:0] ert,
                        input logic br, input logic rsm, input bit do_chk);
        bit lu;
        logic e_pc, e_ifw, e_fl, e_nop, e_hlt;
        bus.id_opcode = op;  bus.id_rs = rs;  bus.id_rt = rt;
        bus.ex_mem_read = mr;  bus.ex_rt = ert;
        bus.ex_branch_taken = br;  bus.resume = rsm;
        lu = mr && (ert != 5'd0) &&
             (((op inside {6'b000000, 6'b001000, 6'b001001, 6'b000100,
                           6'b000101, 6'b100011, 6'b101011}) && (ert == rs)) ||
              ((op inside {6'b000000, 6'b000100, 6'b000101, 6'b101011}) && (ert == rt)));
        e_pc = 1'b0; e_ifw = 1'b0; e_fl = 1'b0; e_nop = 1'b1; e_hlt = 1'b0;
        if (boot_left > 0) begin
            e_pc = 1'b1; e_ifw = 1'b1;
        end else if (drain_left > 0) begin
            e_nop = 1'b1;
        end else if (halt_m) begin
            e_hlt = 1'b1;
            if (rsm) begin e_ifw = 1'b1; e_fl = 1'b1; end
        end else if (br) begin
            e_pc = 1'b1; e_ifw = 1'b1; e_fl = 1'b1;
        end else if (lu || op == 6'b111111) begin
            e_nop = 1'b1;
        end else begin
            e_pc = 1'b1; e_ifw = 1'b1; e_nop = 1'b0;
        end
        @(negedge clk);
        if (do_chk) begin
            chk({tag, ".pc_write"},   16'(bus.pc_write),   16'(e_pc));
            chk({tag, ".ifid_write"}, 16'(bus.ifid_write), 16'(e_ifw));
            chk({tag, ".ifid_flush"}, 16'(bus.ifid_flush), 16'(e_fl));
            chk({tag, ".id_nop"},     16'(bus.id_nop),     16'(e_nop));
            chk({tag, ".halted"},     16'(bus.halted),     16'(e_hlt));
            chk({tag, ".stall_cnt"},  bus.stall_cnt,       stall_m);
            chk({tag, ".flush_cnt"},  bus.flush_cnt,       flush_m);
        end
        @(posedge clk);
        if (boot_left > 0) begin
            boot_left--;
        end else if (drain_left > 0) begin
            drain_left--;
            if (drain_left == 0) halt_m = 1'b1;
        end else if (halt_m) begin
            if (rsm) halt_m = 1'b0;
        end else if (br) begin
            if (flush_m != 16'hFFFF) flush_m++;
        end else if (lu) begin
            if (stall_m != 16'hFFFF) stall_m++;
        end else if (op == 6'b111111) begin
            drain_left = 3;
        end
        #1;
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1 chk_boot_outputs(tag);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        logic [5:0] ops [10];
        ops = '{6'b000000, 6'b001000, 6'b001001, 6'b000100, 6'b000101,
                6'b100011, 6'b101011, 6'b000010, 6'b111111, 6'b001100};
        bus.id_opcode = 6'd0; bus.id_rs = 5'd0; bus.id_rt = 5'd0;
        bus.ex_mem_read = 1'b0; bus.ex_rt = 5'd0;
        bus.ex_branch_taken = 1'b0; bus.resume = 1'b0;
        rst_n = 1'b1;
        model_reset();
        #1 rst_n = 1'b0;
        #2 chk_boot_outputs("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Boot bubbles: branch ignored, first real issue on cycle 2
        step("boot0", 6'b001000, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
        step("boot1", 6'b001000, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
        step("boot2", 6'b001000, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);

        // Load-use stall for one cycle, then cases that must not stall
        step("lu_rtype", 6'b000000, 5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
        chk("lu_stall_cnt_one", bus.stall_cnt, 16'd1);
        step("lu_after", 6'b000000, 5'd1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        step("lu_addi_rt", 6'b001000, 5'd3, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
        step("lu_r0", 6'b000000, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1);

        // Taken branch beats halt in ID: flush, no drain
        step("br_halt", 6'b111111, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1);
        chk("br_flush_cnt_one", bus.flush_cnt, 16'd1);
        step("br_after", 6'b001000, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);

        // Halt: detect + 3 drain cycles, halted on the 5th, hazards ignored, then resume
        step("halt_det", 6'b111111, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)
            step("drain", 6'b111111, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1);
        chk("halted_5th", 16'(bus.halted), 16'd1);
        step("halted_idle", 6'b111111, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1);
        step("resume", 6'b111111, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        step("post_resume", 6'b000000, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        step("fetch", 6'b001000, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            step("rand", ops[$urandom_range(0, 9)], 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) == 0), 1'b1);
        end

        // Stall counter saturation
        do_reset("rst_sat");
        step("sat_boot0", 6'b001000, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        step("sat_boot1", 6'b001000, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 65535; i++)
            step("sat", 6'b000000, 5'd5, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        chk("sat_reach", bus.stall_cnt, 16'hFFFF);
        step("sat_hold", 6'b000000, 5'd5, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
        chk("sat_hold_after", bus.stall_cnt, 16'hFFFF);

        // Reset in drain cycle 2 abandons the drain and repeats boot
        do_reset("rst_pre");
        step("d_boot0", 6'b001000, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        step("d_boot1", 6'b001000, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        step("d_branch", 6'b001000, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
        step("d_halt", 6'b111111, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        step("d_drain1", 6'b111111, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        model_reset();
        #1 chk_boot_outputs("rst_drain");
        @(posedge clk);
        #1 rst_n = 1'b1;
        step("r_boot0", 6'b111111, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        step("r_boot1", 6'b111111, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        step("r_run", 6'b001000, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
